// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared CPU word and RAM handshake types
// Revision 1.0 : initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/dp_types_pkg.sv
`default_nettype none
// ============================================================================
// dp_types_pkg : datapath-side types (memory arbiter state)
// Revision 1.0 : initial release
// ============================================================================
package dp_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// mem_request_arbiter : single-ported RAM arbiter, data over instruction with
//                       a bounded data streak so fetch cannot starve.
// Revision 1.0 : initial release
// ============================================================================
module mem_request_arbiter
    import cpu_types_pkg::*, dp_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    ramstate_t     rs;
    arb_state_t    state_q, state_d, arb_pick;
    logic [SW-1:0] streak_q, streak_d;
    logic          memerr_q, memerr_d;
    logic          dreq, data_done, inst_done;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

    always_comb begin
        data_done = (state_q == DATA) && (rs == ACCESS);
        inst_done = (state_q == INST) && (rs == ACCESS);

        streak_d = streak_q;
        if (!iREN || inst_done) begin
            streak_d = '0;
        end else if (data_done && (streak_q != LIMIT)) begin
            streak_d = streak_q + SW'(1);
        end

        // Arbitration sees the post-completion streak so the limit is exact.
        if (dreq && !(iREN && (streak_d == LIMIT))) begin
            arb_pick = DATA;
        end else if (iREN) begin
            arb_pick = INST;
        end else begin
            arb_pick = IDLE;
        end

        state_d = state_q;
        case (state_q)
            IDLE: state_d = arb_pick;
            DATA: begin
                if (data_done) begin
                    state_d = arb_pick;
                end else if (!dreq) begin
                    state_d = IDLE;
                end
            end
            INST: begin
                if (inst_done) begin
                    state_d = arb_pick;
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        memerr_d = memerr_q;
        if (((state_q == DATA) || (state_q == INST)) && (rs == ERROR)) begin
            memerr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            memerr_q <= memerr_d;
        end
    end

    // RAM side and waits follow the current grant combinationally.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        case (state_q)
            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (data_done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            INST: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (inst_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

    assign memerr = memerr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_request_arbiter : directed scenarios plus randomized run against a
//                          transaction-level model of the arbiter.
// Revision 1.0 : initial release
// ============================================================================
module tb_mem_request_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int total = 0;
    int bad   = 0;

    mem_request_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: owner 0 = nobody, 1 = data port, 2 = instruction port.
    int m_owner  = 0;
    int m_streak = 0;
    bit m_err    = 1'b0;

    function automatic int pick_owner(input bit dq, input bit iq, input int streak);
        if (dq && !(iq && streak == LIMIT)) return 1;
        if (iq) return 2;
        return 0;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        bit dq, done;
        if (!nRST) begin
            m_owner  = 0;
            m_streak = 0;
            m_err    = 1'b0;
        end else begin
            dq   = dREN || dWEN;
            done = (m_owner != 0) && (ramstate == RS_ACC);
            if (m_owner != 0 && ramstate == RS_ERR) m_err = 1'b1;
            if (!iREN) m_streak = 0;
            else if (done && m_owner == 2) m_streak = 0;
            else if (done && m_owner == 1 && m_streak < LIMIT) m_streak = m_streak + 1;
            if (m_owner == 0 || done) m_owner = pick_owner(dq, iREN, m_streak);
            else if ((m_owner == 1 && !dq) || (m_owner == 2 && !iREN)) m_owner = 0;
        end
    end

    logic [132:0] exp_v, act_v;
    always_comb begin
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_st, e_il, e_dl;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_st = 32'd0;
        e_iw = 1'b1; e_dw = 1'b1; e_il = 32'd0; e_dl = 32'd0;
        if (m_owner == 1) begin
            e_addr = daddr; e_st = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
            if (ramstate == RS_ACC) begin e_dw = 1'b0; e_dl = ramload; end
        end else if (m_owner == 2) begin
            e_addr = iaddr; e_ren = iREN;
            if (ramstate == RS_ACC) begin e_iw = 1'b0; e_il = ramload; end
        end
        exp_v = {e_ren, e_wen, e_addr, e_st, e_iw, e_il, e_dw, e_dl, m_err};
        act_v = {ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait, dload, memerr};
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ramREN, ramWEN, memerr} !== 3'b000) begin
            bad++; $display("FAIL reset_enables: got %b want 000", {ramREN, ramWEN, memerr});
        end
        total++;
        if ({iwait, dwait} !== 2'b11) begin
            bad++; $display("FAIL reset_waits: got %b want 11", {iwait, dwait});
        end
        total++;
        if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
            bad++; $display("FAIL reset_buses: got %h want 0", {ramaddr, ramstore, iload, dload});
        end
        step(); nRST = 1'b1;
    endtask

    task automatic test_single_fetch();
        step(); iREN = 1'b1; iaddr = 32'h40; ramstate = RS_FREE; #1;
        total++;
        if (ramREN !== 1'b0) begin bad++; $display("FAIL fetch_cycle0_ren: got %b want 0", ramREN); end
        for (int c = 0; c < 2; c++) begin
            step(); ramstate = RS_BUSY; #1;
            total++;
            if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h40, 1'b1}) begin
                bad++; $display("FAIL fetch_busy%0d: got ren=%b addr=%h iwait=%b want 1/40/1", c, ramREN, ramaddr, iwait);
            end
        end
        step(); ramstate = RS_ACC; ramload = 32'h8C220004; iREN = 1'b0; #1;
        total++;
        if ({iwait, iload} !== {1'b0, 32'h8C220004}) begin
            bad++; $display("FAIL fetch_access: got iwait=%b iload=%h want 0/8c220004", iwait, iload);
        end
        step(); ramstate = RS_FREE; #1;
        total++;
        if ({ramREN, ramaddr, iwait, iload} !== {1'b0, 32'h0, 1'b1, 32'h0}) begin
            bad++; $display("FAIL fetch_idle: got ren=%b addr=%h iwait=%b iload=%h want 0/0/1/0", ramREN, ramaddr, iwait, iload);
        end
    endtask

    task automatic test_priority();
        step(); iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h100; ramstate = RS_FREE; #1;
        step(); ramstate = RS_ACC; ramload = 32'h11; dREN = 1'b0; #1;
        total++;
        if ({ramaddr, dwait, dload, iwait} !== {32'h100, 1'b0, 32'h11, 1'b1}) begin
            bad++; $display("FAIL prio_data_first: got addr=%h dwait=%b dload=%h iwait=%b want 100/0/11/1", ramaddr, dwait, dload, iwait);
        end
        step(); ramstate = RS_BUSY; #1;
        total++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h44}) begin
            bad++; $display("FAIL prio_inst_next: got ren=%b addr=%h want 1/44", ramREN, ramaddr);
        end
        step(); ramstate = RS_ACC; ramload = 32'h22; iREN = 1'b0; #1;
        total++;
        if ({iwait, iload} !== {1'b0, 32'h22}) begin
            bad++; $display("FAIL prio_inst_done: got iwait=%b iload=%h want 0/22", iwait, iload);
        end
        step(); ramstate = RS_FREE; #1;
    endtask

    task automatic test_write_wins();
        step(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; #1;
        step(); ramstate = RS_BUSY; #1;
        total++;
        if ({ramWEN, ramREN, ramstore, ramaddr, dwait} !== {1'b1, 1'b0, 32'hDEADBEEF, 32'h200, 1'b1}) begin
            bad++; $display("FAIL write_wins: got wen=%b ren=%b st=%h addr=%h dwait=%b", ramWEN, ramREN, ramstore, ramaddr, dwait);
        end
        step(); ramstate = RS_ACC; ramload = 32'h5A5A; dREN = 1'b0; dWEN = 1'b0; #1;
        total++;
        if (dwait !== 1'b0) begin bad++; $display("FAIL write_done: got dwait=%b want 0", dwait); end
        step(); ramstate = RS_FREE; #1;
        total++;
        if (ramWEN !== 1'b0) begin bad++; $display("FAIL write_release: got wen=%b want 0", ramWEN); end
    endtask

    task automatic test_starvation();
        int kind, want;
        step(); dREN = 1'b1; iREN = 1'b1; daddr = 32'h300; iaddr = 32'h80; ramstate = RS_ACC; ramload = 32'h77; #1;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            kind = (!dwait && iwait) ? 1 : ((!iwait && dwait) ? 2 : 0);
            want = (i % 5 == 4) ? 2 : 1;
            total++;
            if (kind !== want) begin
                bad++; $display("FAIL starve_grant%0d: got port %0d want %0d", i, kind, want);
            end
        end
        step(); dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE; #1;
        step(); #1;
    endtask

    task automatic test_error_abort();
        step(); iREN = 1'b1; iaddr = 32'h60; ramstate = RS_FREE; #1;
        step(); ramstate = RS_ERR; #1;
        total++;
        if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h60, 1'b1}) begin
            bad++; $display("FAIL err_hold: got ren=%b addr=%h iwait=%b want 1/60/1", ramREN, ramaddr, iwait);
        end
        step(); #1;
        total++;
        if ({memerr, iwait} !== 2'b11) begin
            bad++; $display("FAIL err_flag: got memerr=%b iwait=%b want 1/1", memerr, iwait);
        end
        step(); iREN = 1'b0; ramstate = RS_BUSY; #1;
        total++;
        if ({ramREN, iwait} !== 2'b01) begin
            bad++; $display("FAIL abort_comb: got ren=%b iwait=%b want 0/1", ramREN, iwait);
        end
        step(); ramstate = RS_FREE; #1;
        total++;
        if ({ramREN, ramaddr, memerr} !== {1'b0, 32'h0, 1'b1}) begin
            bad++; $display("FAIL abort_idle: got ren=%b addr=%h memerr=%b want 0/0/1", ramREN, ramaddr, memerr);
        end
    endtask

    task automatic test_reset_mid();
        step(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h400; dstore = 32'h1234; ramstate = RS_FREE; #1;
        step(); ramstate = RS_BUSY; #1;
        total++;
        if (ramWEN !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got wen=%b want 1", ramWEN); end
        #2 nRST = 1'b0; #1;
        total++;
        if ({ramWEN, ramREN, memerr, dwait} !== 4'b0001) begin
            bad++; $display("FAIL rstmid_async: got wen/ren/err/dwait=%b want 0001", {ramWEN, ramREN, memerr, dwait});
        end
        step(); nRST = 1'b1; #1;
        step(); #1;
        total++;
        if ({ramWEN, ramaddr} !== {1'b1, 32'h400}) begin
            bad++; $display("FAIL rstmid_regrant: got wen=%b addr=%h want 1/400", ramWEN, ramaddr);
        end
        step(); ramstate = RS_ACC; dREN = 1'b0; dWEN = 1'b0; #1;
        total++;
        if (dwait !== 1'b0) begin bad++; $display("FAIL rstmid_done: got dwait=%b want 0", dwait); end
        step(); ramstate = RS_FREE; #1;
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            step();
            if ($urandom_range(3) == 0) dREN = ~dREN;
            if ($urandom_range(5) == 0) dWEN = ~dWEN;
            if ($urandom_range(3) == 0) iREN = ~iREN;
            if ($urandom_range(7) == 0) daddr = $urandom;
            if ($urandom_range(7) == 0) iaddr = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            r = $urandom_range(99);
            ramstate = (r < 40) ? RS_ACC : (r < 70) ? RS_BUSY : (r < 85) ? RS_FREE : RS_ERR;
            #1;
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL random_cycle%0d: got %h want %h", c, act_v, exp_v);
            end
        end
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = RS_FREE;
        test_reset();
        test_single_fetch();
        test_priority();
        test_write_wins();
        test_starvation();
        test_error_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
